rr_sel_arbiter: RTL and testbench

- Four-requester round-robin arbiter that generates the registered 2-bit select for the downstream 4:1 data mux.
- Each requester owns one mux input. The arbiter grants one owner at a time and holds the grant until release. It drives `sel` so the mux output follows the granted source.
- The `gnt_valid` qualifier tells consumers when the mux output is meaningful.

---
 rtl/rr_sel_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rr_sel_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// -----------------------------------------------------------------------------
// rr_sel_arbiter
//   Four-requester round-robin arbiter that produces the registered select
//   for a downstream 4:1 data mux. One owner holds the grant at a time and
//   keeps it until it releases it. It releases by pulsing done, by dropping
//   its request, or by reaching the per-owner hold limit.
//
//   Optional build macro: RR_SEL_ASSERT_EN
//     When defined, immediate assertions check the output invariants
//     (gnt one-hot or zero, gnt_valid == |gnt, gnt == 1<<sel while valid).
//     A clocked assertion checks the hold counter bound.
//     When undefined, no checks are compiled and behaviour is identical.
//
// Parameters
//   NUM_REQ   number of requesters (must be 4, matches the mux)
//   SEL_W     select width, $clog2(NUM_REQ)
//   HOLD_MAX  maximum consecutive grant cycles per owner, 0 = unlimited
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [NUM_REQ-1:0] request vector, req[i] = source i wants the mux
//   done       in   current owner releases its grant this cycle
//   gnt        out  [NUM_REQ-1:0] registered one-hot grant, zero when idle
//   sel        out  [SEL_W-1:0] registered mux select, current or last owner
//   gnt_valid  out  high while a grant is active
//
// Handshake: the arbiter samples req/done on every rising edge. All outputs
// are registered, so a request seen at edge N is reflected after edge N.
// There is no combinational path from req or done to any output.
// -----------------------------------------------------------------------------
module rr_sel_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int SEL_W    = $clog2(NUM_REQ),
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               gnt_valid
);

  generate
    if (NUM_REQ != 4) begin : g_bad_num_req
      $fatal(1, "rr_sel_arbiter: NUM_REQ must be 4");
    end
  endgenerate

  // Hold counter width, at least one bit even when HOLD_MAX is 0.
  localparam int HC_W = ($clog2(HOLD_MAX + 1) < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   last, last_n;
  logic [HC_W-1:0]    hold_cnt, hold_cnt_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [SEL_W-1:0]   sel_n;
  logic               gnt_valid_n;

  logic               win_found;
  logic [SEL_W-1:0]   win_idx;
  logic [SEL_W-1:0]   cand;
  logic               hold_hit;
  logic               release_owner;

  // Winner search: scan from last+1 upward with natural SEL_W-bit wrap, so
  // the previous owner is checked last and has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign hold_hit      = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);
  assign release_owner = done || !req[sel] || hold_hit;

  always_comb begin
    state_n     = state;
    last_n      = last;
    hold_cnt_n  = hold_cnt;
    gnt_n       = gnt;
    sel_n       = sel;
    gnt_valid_n = gnt_valid;
    unique case (state)
      IDLE: begin
        // done has no meaning without an owner and is ignored here.
        if (win_found) begin
          state_n     = GRANT;
          gnt_n       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          sel_n       = win_idx;
          last_n      = win_idx;
          gnt_valid_n = 1'b1;
          hold_cnt_n  = '0;
        end
      end
      GRANT: begin
        if (release_owner) begin
          // Re-arbitrate on the same edge so a hand-off costs no bubble.
          // A sole remaining requester (even the old owner) wins again.
          if (win_found) begin
            gnt_n      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            sel_n      = win_idx;
            last_n     = win_idx;
            hold_cnt_n = '0;
          end else begin
            // sel keeps pointing at the last owner while idle.
            state_n     = IDLE;
            gnt_n       = '0;
            gnt_valid_n = 1'b0;
            hold_cnt_n  = '0;
          end
        end else begin
          hold_cnt_n = (HOLD_MAX == 0) ? '0 : hold_cnt + HC_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= SEL_W'(NUM_REQ - 1);  // index 0 gets first priority
      hold_cnt  <= '0;
      gnt       <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      hold_cnt  <= hold_cnt_n;
      gnt       <= gnt_n;
      sel       <= sel_n;
      gnt_valid <= gnt_valid_n;
    end
  end

`ifdef RR_SEL_ASSERT_EN
  always_comb begin
    a_gnt_onehot0: assert ($onehot0(gnt))
      else $error("rr_sel_arbiter: gnt not onehot0 at %0t", $time);
    a_valid_matches_gnt: assert (gnt_valid == (|gnt))
      else $error("rr_sel_arbiter: gnt_valid != |gnt at %0t", $time);
    a_gnt_matches_sel: assert (!gnt_valid || (gnt == ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel)))
      else $error("rr_sel_arbiter: gnt != 1<<sel at %0t", $time);
  end

  always_ff @(posedge clk) begin
    if (rst_n && (HOLD_MAX != 0)) begin
      a_hold_cnt_bound: assert (int'(hold_cnt) < HOLD_MAX)
        else $error("rr_sel_arbiter: hold_cnt out of range at %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_sel_arbiter
//   Self-checking bench for rr_sel_arbiter built with HOLD_MAX = 4.
//   The reference model tracks "who owns the mux" and "how many cycles it has
//   held it" as plain integers and applies the round-robin rules directly.
// -----------------------------------------------------------------------------
module tb_rr_sel_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       gnt_valid;

  rr_sel_arbiter #(
    .NUM_REQ (4),
    .SEL_W   (2),
    .HOLD_MAX(HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .sel      (sel),
    .gnt_valid(gnt_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_owner;  // -1 when nobody owns the mux
  int m_last;   // last owner, start of the next search
  int m_sel;    // index the select points at
  int m_held;   // cycles the current owner has held the grant

  // Scoreboard of {gnt, sel, gnt_valid} expected after each edge.
  logic [6:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (from + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_held  = 0;
  endfunction

  function automatic void model_grant(input int w);
    m_owner = w;
    m_sel   = w;
    m_last  = w;
    m_held  = 1;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    int w;
    w = pick(r, m_last);
    if (m_owner < 0) begin
      if (w >= 0) model_grant(w);
    end else if (d || !r[m_owner] || (HOLD != 0 && m_held == HOLD)) begin
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end else begin
      m_held++;
    end
  endfunction

  function automatic logic [6:0] model_out();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    return {g, 2'(m_sel), (m_owner >= 0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [6:0] e;
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({gnt, sel, gnt_valid} !== 7'b0000_00_0) begin
      n_err++;
      $display("FAIL reset_hold: got gnt=%b sel=%0d valid=%b, want 0000/0/0", gnt, sel, gnt_valid);
    end
    rst_n = 1'b1;
    tick(4'b1111, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if ({gnt, sel, gnt_valid} !== e || gnt !== 4'b0001 || sel !== 2'd0) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b/%0d/%b, want 0001/0/1", gnt, sel, gnt_valid);
    end
  endtask

  task automatic test_single_request();
    logic [6:0] e;
    do_reset();
    tick(4'b0000, 1'b0);
    void'(exp_q.pop_front());
    req = 4'b0100;
    #2;
    n_vec++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_before_edge: got gnt=%b valid=%b, want 0000/0", gnt, gnt_valid);
    end
    tick(4'b0100, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if ({gnt, sel, gnt_valid} !== e || {gnt, sel, gnt_valid} !== 7'b0100_10_1) begin
      n_err++;
      $display("FAIL single_grant: got %b/%0d/%b, want 0100/2/1", gnt, sel, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    logic [6:0] e;
    int want [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(4'b1111, (i != 0));
      e = exp_q.pop_front();
      n_vec++;
      if ({gnt, sel, gnt_valid} !== e || sel !== 2'(want[i]) || gnt_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rotation_%0d: got sel=%0d valid=%b, want sel=%0d valid=1", i, sel, gnt_valid, want[i]);
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [6:0] e;
    logic [3:0] want_g;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(4'b0011, 1'b0);
      e = exp_q.pop_front();
      want_g = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
      n_vec++;
      if ({gnt, sel, gnt_valid} !== e || gnt !== want_g) begin
        n_err++;
        $display("FAIL hold_limit_%0d: got gnt=%b, want %b", i, gnt, want_g);
      end
    end
  endtask

  task automatic test_owner_drop();
    logic [6:0] e;
    do_reset();
    tick(4'b1000, 1'b0);
    tick(4'b1000, 1'b0);
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    n_vec++;
    if ({gnt, sel, gnt_valid} !== e || gnt !== 4'b1000) begin
      n_err++;
      $display("FAIL drop_granted: got gnt=%b, want 1000", gnt);
    end
    tick(4'b0000, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if ({gnt, sel, gnt_valid} !== e || {gnt, sel, gnt_valid} !== 7'b0000_11_0) begin
      n_err++;
      $display("FAIL drop_idle: got %b/%0d/%b, want 0000/3/0", gnt, sel, gnt_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [6:0] e;
    do_reset();
    tick(4'b0010, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if ({gnt, sel, gnt_valid} !== e || gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL midrst_granted: got gnt=%b, want 0010", gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt, sel, gnt_valid} !== 7'b0000_00_0) begin
      n_err++;
      $display("FAIL midrst_async_clear: got %b/%0d/%b, want 0000/0/0", gnt, sel, gnt_valid);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(4'b1010, 1'b0);
    e = exp_q.pop_front();
    n_vec++;
    if ({gnt, sel, gnt_valid} !== e || sel !== 2'd1 || gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL midrst_restart: got gnt=%b sel=%0d, want 0010/1", gnt, sel);
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    logic [3:0] r;
    logic       d;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0);
      tick(r, d);
      e = exp_q.pop_front();
      n_vec++;
      if ({gnt, sel, gnt_valid} !== e) begin
        n_err++;
        $display("FAIL random_%0d: req=%b done=%b got %b/%0d/%b, want %b/%0d/%b",
                 i, r, d, gnt, sel, gnt_valid, e[6:3], e[2:1], e[0]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    model_reset();
    test_reset();
    test_single_request();
    test_rotation();
    test_hold_limit();
    test_owner_drop();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
